fft_bitrev_buffer: RTL
======================

Name: fft_bitrev_buffer

Overview:
Parametrised double-buffered input stage for the radix-2 FFT processors. It accepts a serial stream of complex samples in natural order and emits each N-point frame in bit-reversed order, with valid/ready handshakes on both sides. Ping-pong banks let one frame load while the previous frame drains. It generalises the fixed 8-point, enable-only serial loading to arbitrary width and power-of-two length, and adds backpressure and frame markers.

Parameters:
DW, 16, sample width in bits of each real and imaginary part (two's complement, passed through unmodified)
LOG2N, 3, log2 of frame length N; legal range 2..6 (N = 4..64)

Ports:
c  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; while low, no transfers occur on either side
in_valid  input  1  input sample present
in_ready  output  1  buffer can accept an input sample
in_re  input  DW  input sample, real part
in_im  input  DW  input sample, imaginary part
out_valid  output  1  output sample present
out_ready  input  1  downstream accepts the output sample
out_re  output  DW  output sample, real part
out_im  output  DW  output sample, imaginary part
out_sof  output  1  first sample of a frame (qualified by out_valid)
out_eof  output  1  last sample of a frame (qualified by out_valid)

Behaviour:
- One clock domain and one reset. Reset is asynchronous and active-low.
- Storage: 2 banks x N entries x 2*DW bits, held in registers. All storage resets to 0.
- State registers:
  - wb: write bank, 1 bit.
  - rb: read bank, 1 bit.
  - wcnt: write count, LOG2N bits.
  - rcnt: read count, LOG2N bits.
  - fcnt: full-bank count, 0..2.
  - All reset to 0.
- Reset values of outputs: in_ready=0 while rst_n=0, then follows its equation. out_valid=0, out_re=0, out_im=0, out_sof=0, out_eof=0.
- Write side:
  - in_ready = en & (fcnt<2).
  - Accept when in_valid & in_ready.
  - The k-th accepted sample of a frame (k=wcnt) is written to bank wb at address bitrev(k), where bitrev reverses the LOG2N-bit index.
  - On accept with wcnt==N-1: wcnt wraps to 0, wb toggles and fcnt increments. Otherwise wcnt increments.
- Read side:
  - out_valid = en & (fcnt>0).
  - out_re/out_im = bank rb at address rcnt (combinational read of registered storage). They are 0 whenever out_valid=0.
  - out_sof = out_valid & (rcnt==0).
  - out_eof = out_valid & (rcnt==N-1).
  - Transfer when out_valid & out_ready.
  - On transfer with rcnt==N-1: rcnt wraps to 0, rb toggles and fcnt decrements. Otherwise rcnt increments.
- If a frame completes on the write side and a frame completes on the read side in the same cycle, fcnt is unchanged.
- Latency: out_valid rises on the clock edge that accepts the last (N-th) input sample, i.e. first output visible the cycle after. With in_valid and out_ready held high, throughput is 1 sample/cycle sustained with no bubbles.
- Full: fcnt==2 forces in_ready=0. Input stalls until the drain of the current read frame completes.
- Empty: fcnt==0 forces out_valid=0.
- en=0: both handshakes are blocked and all counters and storage hold. A partial frame resumes when en returns to 1.
- Reset mid-operation: immediate clear. The partial input frame and any full banks are discarded.

Optional Feature:
Macro FFTBUF_OVF_ERR_EN.
- Defined: adds output port err_ovf (1 bit, reset 0). It is set sticky on any rising edge where in_valid=1 and in_ready=0 with en=1, and cleared only by rst_n.
- Undefined: the port and its logic are absent. Dropped pushes are silently ignored.

Test Plan:
1. Reset, then push xr=0..7 with xi=-1 (16'hFFFF), out_ready=1. Output must be out_re=0,4,2,6,1,5,3,7 with out_im=16'hFFFF on every sample. out_sof is high on 0 and out_eof on 7. out_valid rises the cycle after the 8th accept.
2. Two back-to-back frames 0..7 and 8..15, out_ready=1. Output must be continuous with no gap: second frame 8,12,10,14,9,13,11,15. in_ready stays 1 throughout.
3. out_ready=0, push 24 samples. in_ready must fall after the 16th accept, with fcnt=2. Release out_ready: frame 1 drains, then in_ready returns to 1 and samples 16..23 load.
4. en dropped for 4 cycles after 3 accepted samples. in_ready and out_valid must be 0 and no samples lost. After resume, the frame output must be 0,4,2,6,1,5,3,7.
5. rst_n pulsed low between edges mid-frame (5 samples in, one frame full). All outputs must go 0 immediately with no clock edge. After release, a fresh 0..7 frame must output in bit-reversed order with no stale data.
6. With FFTBUF_OVF_ERR_EN, test plan 3 holding in_valid=1 while in_ready=0. err_ovf must go 1 and stay 1 after the stall clears, until rst_n. LOG2N=2 run of 0..3 must output 0,2,1,3.

Source files
------------

// File: rtl/fft_bitrev_buffer_if.sv
// Valid/ready handshake bundle for the bit-reversal buffer: the natural-order input
// stream and the bit-reversed output stream with its frame markers.
interface fft_bitrev_buffer_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic          out_sof;
    logic          out_eof;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_sof, out_eof
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_sof, out_eof
    );
endinterface

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong input buffer: loads N=2**LOG2N complex samples in natural order, drains them bit-reversed.
// Optional sticky overflow flag err_ovf when FFTBUF_OVF_ERR_EN is defined. LOG2N legal range 2..6.
module fft_bitrev_buffer #(
    parameter int DW    = 16,
    parameter int LOG2N = 3
) (
    input  logic c,
    input  logic rst_n,
    input  logic en,
`ifdef FFTBUF_OVF_ERR_EN
    output logic err_ovf,
`endif
    fft_bitrev_buffer_if.slave bus
);
    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST = '1;
    localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

    logic [2*DW-1:0]  mem_q [2][N];
    logic             wb_q, wb_d, rb_q, rb_d;
    logic [LOG2N-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic             in_ready, out_valid, push, pop, wlast, rlast;
    logic [2*DW-1:0]  rd_word;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
        for (int i = 0; i < LOG2N; i++) bitrev[i] = k[LOG2N-1-i];
    endfunction

    // rst_n gating keeps in_ready low for the whole reset pulse, not just after the first edge
    assign in_ready  = rst_n & en & (fcnt_q != 2'd2);
    assign out_valid = en & (fcnt_q != 2'd0);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;
    assign wlast     = push & (wcnt_q == LAST);
    assign rlast     = pop & (rcnt_q == LAST);
    assign rd_word   = mem_q[rb_q][rcnt_q];

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_re    = out_valid ? rd_word[2*DW-1:DW] : '0;
    assign bus.out_im    = out_valid ? rd_word[DW-1:0]    : '0;
    assign bus.out_sof   = out_valid & (rcnt_q == '0);
    assign bus.out_eof   = out_valid & (rcnt_q == LAST);

    always_comb begin
        wb_d   = wb_q;
        rb_d   = rb_q;
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        fcnt_d = fcnt_q;
        if (push) wcnt_d = wcnt_q + ONE;
        if (pop)  rcnt_d = rcnt_q + ONE;
        if (wlast) wb_d = ~wb_q;
        if (rlast) rb_d = ~rb_q;
        case ({wlast, rlast})
            2'b10:   fcnt_d = fcnt_q + 2'd1;
            2'b01:   fcnt_d = fcnt_q - 2'd1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            wcnt_q <= '0;
            rcnt_q <= '0;
            fcnt_q <= '0;
        end else begin
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Scatter on write so the read side is a plain sequential sweep
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < N; a++)
                    mem_q[b][a] <= '0;
        end else if (push) begin
            mem_q[wb_q][bitrev(wcnt_q)] <= {bus.in_re, bus.in_im};
        end
    end

`ifdef FFTBUF_OVF_ERR_EN
    logic err_ovf_q;

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n)
            err_ovf_q <= 1'b0;
        else if (en & bus.in_valid & ~in_ready)
            err_ovf_q <= 1'b1;
    end

    assign err_ovf = err_ovf_q;
`endif
endmodule
